shift_arbiter_seq: RTL and testbench

- Two-requester arbiter and multi-pass sequencer for the shared 8-bit barrel shifter pair (left unit plus right unit with logical, arithmetic and rotate modes).
- Accepts shift requests with amounts 0–255 and splits each into passes of at most MAX_STEP bits.
- Drives the shifter's data/control inputs once per pass and accumulates the result.
- Sits between the ALU-side requesters and the shifter units in the CPU datapath.

---
 rtl/shift_arbiter_seq.sv | 168 ++++++++++++++++
 tb/tb_shift_arbiter_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter_seq.sv
// shift_arbiter_seq: two-requester arbiter and multi-pass sequencer for the
// shared 8-bit barrel shifter pair (left unit + right unit LSR/ASR/ROR).
// A request of amount 0..255 is split into passes of at most MAX_STEP bits.
// One pass is driven onto the shifter per RUN cycle. The result
// accumulates in r_acc and is returned with a one-cycle resp pulse.
//
// Ports:
//   CLK, RESET            rising-edge clock, synchronous active-high reset
//   reqN_valid/data/amt/op  request N (op: 00 LSR, 01 ASR, 10 ROR, 11 LSL)
//   reqN_ready            combinational accept strobe (IDLE, granted)
//   respN_valid/data      one-cycle result pulse; data holds between pulses
//   sh_data, sh_ctrl      shifter operand and {op, 3'b000, step}
//   sh_sel_left           select left-unit result (LSL)
//   sh_result             selected shifter result (combinational)
//
// Optional macro SHIFT_SAT_SHORTCUT_EN: saturating shortcut at accept for
// amounts >= 8 (LSL/LSR -> 0, ASR -> sign fill, ROR -> amt mod 8).

module shift_arbiter_seq #(
  parameter int unsigned MAX_STEP = 7
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic [7:0] req0_amt,
  input  logic [1:0] req0_op,
  output logic       req0_ready,
  output logic       resp0_valid,
  output logic [7:0] resp0_data,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic [7:0] req1_amt,
  input  logic [1:0] req1_op,
  output logic       req1_ready,
  output logic       resp1_valid,
  output logic [7:0] resp1_data,
  output logic [7:0] sh_data,
  output logic [7:0] sh_ctrl,
  output logic       sh_sel_left,
  input  logic [7:0] sh_result
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [7:0] STEP_MAX = 8'(MAX_STEP);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_acc, w_acc_nxt;
  logic [7:0] r_rem, w_rem_nxt;
  logic [1:0] r_op, w_op_nxt;
  logic       r_id, w_id_nxt;
  logic       r_last_grant, w_last_grant_nxt;
  logic [7:0] r_resp0_data, r_resp1_data;

  logic       w_gnt;
  logic       w_any;
  logic [7:0] w_sel_data;
  logic [7:0] w_sel_amt;
  logic [1:0] w_sel_op;
  logic [2:0] w_step;

  always_comb begin
    w_any      = req0_valid | req1_valid;
    // Only one valid: take it. Both valid: take the one not granted last.
    w_gnt      = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    w_sel_data = w_gnt ? req1_data : req0_data;
    w_sel_amt  = w_gnt ? req1_amt  : req0_amt;
    w_sel_op   = w_gnt ? req1_op   : req0_op;
    w_step     = (r_rem < STEP_MAX) ? r_rem[2:0] : STEP_MAX[2:0];

    w_state_nxt      = r_state;
    w_acc_nxt        = r_acc;
    w_rem_nxt        = r_rem;
    w_op_nxt         = r_op;
    w_id_nxt         = r_id;
    w_last_grant_nxt = r_last_grant;

    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    sh_data     = '0;
    sh_ctrl     = '0;
    sh_sel_left = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_any && !RESET) begin
          req0_ready       = ~w_gnt;
          req1_ready       = w_gnt;
          w_acc_nxt        = w_sel_data;
          w_rem_nxt        = w_sel_amt;
          w_op_nxt         = w_sel_op;
          w_id_nxt         = w_gnt;
          w_last_grant_nxt = w_gnt;
`ifdef SHIFT_SAT_SHORTCUT_EN
          if (w_sel_amt[7:3] != 5'd0) begin
            case (w_sel_op)
              2'b01: begin
                w_acc_nxt = {8{w_sel_data[7]}};
                w_rem_nxt = '0;
              end
              2'b10: w_rem_nxt = {5'd0, w_sel_amt[2:0]};
              default: begin
                w_acc_nxt = '0;
                w_rem_nxt = '0;
              end
            endcase
          end
`endif
          w_state_nxt = (w_rem_nxt != 8'd0) ? ST_RUN : ST_DONE;
        end
      end

      ST_RUN: begin
        sh_data     = r_acc;
        sh_ctrl     = {r_op, 3'b000, w_step};
        sh_sel_left = (r_op == 2'b11);
        w_acc_nxt   = sh_result;
        w_rem_nxt   = r_rem - {5'd0, w_step};
        w_state_nxt = (w_rem_nxt == 8'd0) ? ST_DONE : ST_RUN;
      end

      ST_DONE: begin
        resp0_valid = ~r_id;
        resp1_valid = r_id;
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign resp0_data = r_resp0_data;
  assign resp1_data = r_resp1_data;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_acc        <= '0;
      r_rem        <= '0;
      r_op         <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_resp0_data <= '0;
      r_resp1_data <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_rem        <= w_rem_nxt;
      r_op         <= w_op_nxt;
      r_id         <= w_id_nxt;
      r_last_grant <= w_last_grant_nxt;
      // Result registers load on entry to DONE so the value is visible
      // during the pulse and held afterwards.
      if (w_state_nxt == ST_DONE && r_state != ST_DONE) begin
        if (w_id_nxt) r_resp1_data <= w_acc_nxt;
        else          r_resp0_data <= w_acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter_seq.sv
// Testbench for shift_arbiter_seq: behavioural shifter pair model, table of
// directed single-request vectors, plus hand-written arbitration and
// reset-abort sequences. Expectations follow SHIFT_SAT_SHORTCUT_EN if defined.

module tb_shift_arbiter_seq;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req0_amt, req1_data, req1_amt;
  logic [1:0] req0_op, req1_op;
  logic       req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [7:0] resp0_data, resp1_data;
  logic [7:0] sh_data, sh_ctrl, sh_result;
  logic       sh_sel_left;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  shift_arbiter_seq #(.MAX_STEP(7)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt),
    .req0_op(req0_op), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt),
    .req1_op(req1_op), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data),
    .sh_data(sh_data), .sh_ctrl(sh_ctrl), .sh_sel_left(sh_sel_left),
    .sh_result(sh_result)
  );

  // Shifter pair model: left unit LSL, right unit mode from sh_ctrl[7:6].
  always_comb begin
    logic [15:0] dbl;
    logic [2:0]  s;
    s   = sh_ctrl[2:0];
    dbl = {sh_data, sh_data} >> s;
    if (sh_sel_left) sh_result = sh_data << s;
    else begin
      case (sh_ctrl[7:6])
        2'b00:   sh_result = sh_data >> s;
        2'b01:   sh_result = 8'($signed(sh_data) >>> s);
        2'b10:   sh_result = dbl[7:0];
        default: sh_result = sh_data;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit r, input bit v, input logic [1:0] op,
                         input logic [7:0] d, input logic [7:0] a);
    if (r) begin
      req1_valid = v; req1_op = op; req1_data = d; req1_amt = a;
    end else begin
      req0_valid = v; req0_op = op; req0_data = d; req0_amt = a;
    end
  endtask

  // Called at a falling edge; returns at falling edge + 1 of the resp cycle.
  task automatic wait_resp(input bit r, output logic [7:0] dat, output bit to);
    to = 1'b1;
    dat = '0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (r ? resp1_valid : resp0_valid) begin
        dat = r ? resp1_data : resp0_data;
        to = 1'b0;
        return;
      end
      @(negedge CLK);
    end
  endtask

  // Single request: accept, then watch passes until the resp pulse.
  // lat counts cycles after the accept cycle.
  task automatic do_req(input bit r, input logic [1:0] op, input logic [7:0] d,
                        input logic [7:0] a, output logic [7:0] res,
                        output int lat, output int np, output logic [7:0] c0,
                        output logic [7:0] c1, output bit stray, output bit selbad,
                        output bit to);
    int w;
    res = '0; lat = -1; np = 0; c0 = '0; c1 = '0;
    stray = 1'b0; selbad = 1'b0; to = 1'b0;
    @(negedge CLK);
    set_req(r, 1'b1, op, d, a);
    #1;
    w = 0;
    while (!(r ? req1_ready : req0_ready)) begin
      if (w >= 20) begin
        to = 1'b1;
        set_req(r, 1'b0, op, d, a);
        return;
      end
      @(negedge CLK);
      #1;
      w++;
    end
    @(negedge CLK);
    // Scramble the held operands: they must already be latched.
    set_req(r, 1'b0, ~op, ~d, ~a);
    for (int k = 1; k <= 300; k++) begin
      #1;
      if (sh_ctrl != 8'h00) begin
        if (np == 0) c0 = sh_ctrl;
        else if (np == 1) c1 = sh_ctrl;
        if (sh_sel_left !== (op == 2'b11)) selbad = 1'b1;
        np++;
      end
      if (r ? resp0_valid : resp1_valid) stray = 1'b1;
      if (r ? resp1_valid : resp0_valid) begin
        res = r ? resp1_data : resp0_data;
        lat = k;
        return;
      end
      @(negedge CLK);
    end
    to = 1'b1;
  endtask

  typedef struct {
    bit         r;
    logic [1:0] op;
    logic [7:0] d;
    logic [7:0] a;
    logic [7:0] res;
    int         n;
    logic [7:0] c0;
    logic [7:0] c1;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [7:0] res, dat;
    logic [7:0] c0, c1;
    int lat, np;
    bit stray, selbad, to;

    // op: 0 LSR, 1 ASR, 2 ROR, 3 LSL
    vecs[0]  = '{1'b0, 2'd3, 8'h01, 8'd3,   8'h08, 1,  8'hC3, 8'h00};
    vecs[3]  = '{1'b1, 2'd0, 8'h5A, 8'd0,   8'h5A, 0,  8'h00, 8'h00};
    vecs[5]  = '{1'b1, 2'd0, 8'hF0, 8'd4,   8'h0F, 1,  8'h04, 8'h00};
    vecs[6]  = '{1'b0, 2'd1, 8'h40, 8'd6,   8'h01, 1,  8'h46, 8'h00};
    vecs[7]  = '{1'b1, 2'd2, 8'h12, 8'd7,   8'h24, 1,  8'h87, 8'h00};
`ifdef SHIFT_SAT_SHORTCUT_EN
    vecs[1]  = '{1'b1, 2'd1, 8'h80, 8'd10,  8'hFF, 0,  8'h00, 8'h00};
    vecs[2]  = '{1'b0, 2'd2, 8'h81, 8'd9,   8'hC0, 1,  8'h81, 8'h00};
    vecs[4]  = '{1'b0, 2'd3, 8'h01, 8'd200, 8'h00, 0,  8'h00, 8'h00};
    vecs[8]  = '{1'b0, 2'd1, 8'h9C, 8'd255, 8'hFF, 0,  8'h00, 8'h00};
    vecs[9]  = '{1'b1, 2'd2, 8'h81, 8'd8,   8'h81, 0,  8'h00, 8'h00};
    vecs[10] = '{1'b0, 2'd0, 8'hFF, 8'd14,  8'h00, 0,  8'h00, 8'h00};
`else
    vecs[1]  = '{1'b1, 2'd1, 8'h80, 8'd10,  8'hFF, 2,  8'h47, 8'h43};
    vecs[2]  = '{1'b0, 2'd2, 8'h81, 8'd9,   8'hC0, 2,  8'h87, 8'h82};
    vecs[4]  = '{1'b0, 2'd3, 8'h01, 8'd200, 8'h00, 29, 8'hC7, 8'hC7};
    vecs[8]  = '{1'b0, 2'd1, 8'h9C, 8'd255, 8'hFF, 37, 8'h47, 8'h47};
    vecs[9]  = '{1'b1, 2'd2, 8'h81, 8'd8,   8'h81, 2,  8'h87, 8'h81};
    vecs[10] = '{1'b0, 2'd0, 8'hFF, 8'd14,  8'h00, 2,  8'h07, 8'h07};
`endif

    RESET = 1'b1;
    set_req(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("reset_outputs",
          {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_data,
           resp1_data, sh_data, sh_ctrl, sh_sel_left}, 64'd0);

    // Arbitration: both valid right after reset -> req0 first, then alternate.
    @(negedge CLK);
    set_req(1'b0, 1'b1, 2'd3, 8'h01, 8'd1);
    set_req(1'b1, 1'b1, 2'd0, 8'h80, 8'd1);
    #1;
    check("arb_first", {req0_ready, req1_ready}, 2'b10);
    @(negedge CLK);
    set_req(1'b0, 1'b0, 2'd3, 8'h01, 8'd1);
    wait_resp(1'b0, dat, to);
    check("arb_resp0_timeout", to, 1'b0);
    check("arb_resp0_data", dat, 8'h02);
    check("arb_resp1_quiet", resp1_valid, 1'b0);
    set_req(1'b0, 1'b1, 2'd3, 8'h03, 8'd1);   // re-request during DONE
    #1;
    check("arb_no_ready_done", {req0_ready, req1_ready}, 2'b00);
    @(negedge CLK);
    #1;
    check("arb_alt1", {req0_ready, req1_ready}, 2'b01);
    @(negedge CLK);
    set_req(1'b1, 1'b0, 2'd0, 8'h80, 8'd1);
    wait_resp(1'b1, dat, to);
    check("arb_resp1_timeout", to, 1'b0);
    check("arb_resp1_data", dat, 8'h40);
    set_req(1'b1, 1'b1, 2'd0, 8'h80, 8'd1);
    @(negedge CLK);
    #1;
    check("arb_alt2", {req0_ready, req1_ready}, 2'b10);
    @(negedge CLK);
    set_req(1'b0, 1'b0, 2'd3, 8'h03, 8'd1);
    wait_resp(1'b0, dat, to);
    check("arb_waiting_resp0", {to, dat}, {1'b0, 8'h06});
    @(negedge CLK);
    #1;
    check("arb_waiter_granted", {req0_ready, req1_ready}, 2'b01);
    @(negedge CLK);
    set_req(1'b1, 1'b0, 2'd0, 8'h80, 8'd1);
    wait_resp(1'b1, dat, to);
    check("arb_waiter_resp1", {to, dat}, {1'b0, 8'h40});

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].r, vecs[i].op, vecs[i].d, vecs[i].a,
             res, lat, np, c0, c1, stray, selbad, to);
      check($sformatf("v%0d_timeout", i), to, 1'b0);
      check($sformatf("v%0d_result", i), res, vecs[i].res);
      check($sformatf("v%0d_latency", i), lat, 1 + vecs[i].n);
      check($sformatf("v%0d_passes", i), np, vecs[i].n);
      check($sformatf("v%0d_ctrl0", i), c0, vecs[i].c0);
      check($sformatf("v%0d_ctrl1", i), c1, vecs[i].c1);
      check($sformatf("v%0d_stray_resp", i), stray, 1'b0);
      check($sformatf("v%0d_sel_left", i), selbad, 1'b0);
      @(negedge CLK);
      #1;
      check($sformatf("v%0d_pulse_end", i), {resp0_valid, resp1_valid}, 2'b00);
      check($sformatf("v%0d_data_hold", i),
            vecs[i].r ? resp1_data : resp0_data, vecs[i].res);
    end

    // Reset during the 2nd RUN cycle of a 3-pass LSL (7+7+6).
    @(negedge CLK);
    set_req(1'b0, 1'b1, 2'd3, 8'h01, 8'd20);
    #1;
    check("abort_accept", req0_ready, 1'b1);
    @(negedge CLK);
    set_req(1'b0, 1'b0, 2'd3, 8'h01, 8'd20);
    #1;
    check("abort_run1_ctrl", sh_ctrl, 8'hC7);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("abort_run2_ctrl", {sh_ctrl, sh_data}, {8'hC7, 8'h80});
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("abort_outputs_zero",
          {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_data,
           resp1_data, sh_data, sh_ctrl, sh_sel_left}, 64'd0);
    stray = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      #1;
      if (resp0_valid || resp1_valid || sh_ctrl != 8'h00) stray = 1'b1;
    end
    check("abort_no_resp", stray, 1'b0);
    @(negedge CLK);
    set_req(1'b0, 1'b1, 2'd3, 8'h01, 8'd1);
    set_req(1'b1, 1'b1, 2'd0, 8'h80, 8'd1);
    #1;
    check("abort_req0_first", {req0_ready, req1_ready}, 2'b10);
    @(negedge CLK);
    set_req(1'b0, 1'b0, 2'd3, 8'h01, 8'd1);
    set_req(1'b1, 1'b0, 2'd0, 8'h80, 8'd1);
    wait_resp(1'b0, dat, to);
    check("abort_after_resp0", {to, dat}, {1'b0, 8'h02});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
